// File: rtl/data_packetizer.sv
// data_packetizer: first-word-fall-through FIFO between a free-running word
// source and an AXI4-Stream consumer, cutting the output into PKT_LEN-beat
// packets (M_TLAST on the final beat) and counting completed packets.
//
// Handshake contract: the input side has no backpressure, so a word is
// accepted on any edge where S_VALID=1 and there is room (or a beat leaves in
// the same cycle); otherwise it is dropped and OVERFLOW latches. On the output
// side a beat transfers on a rising edge exactly when M_TVALID=1 and
// M_TREADY=1; M_TVALID never depends on M_TREADY, and M_TDATA/M_TLAST hold
// while a beat waits.
module data_packetizer #(
    parameter int DEPTH   = 16,
    parameter int PKT_LEN = 8
) (
    input  logic                     ACLK,
    input  logic                     RST,
    input  logic [31:0]              S_TDATA,
    input  logic                     S_VALID,
    output logic [31:0]              M_TDATA,
    output logic                     M_TVALID,
    input  logic                     M_TREADY,
    output logic                     M_TLAST,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic [15:0]              PKT_CNT,
    output logic [15:0]              BEAT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [15:0]   LAST_BEAT  = 16'(PKT_LEN - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          overflow_q;
    logic [15:0]   pkt_cnt_q;
    logic [15:0]   beat_q;

    logic          xfer;
    logic          wr_en;
    logic          drop;

    // Output decode and accept/drop decision, all from registered state plus
    // the current-cycle strobes; a full FIFO may still accept when a beat
    // leaves on the same edge.
    always_comb begin
        M_TVALID = (level_q != '0);
        M_TDATA  = M_TVALID ? mem[rd_ptr] : 32'd0;
        M_TLAST  = M_TVALID && (beat_q == LAST_BEAT);
        xfer     = M_TVALID && M_TREADY;
        wr_en    = S_VALID && ((level_q != FULL_LEVEL) || xfer);
        drop     = S_VALID && !wr_en;
    end

    // Storage array: contents are don't-care until written, so no reset.
    always_ff @(posedge ACLK) begin
        if (wr_en && !RST) begin
            mem[wr_ptr] <= S_TDATA;
        end
    end

    // Control state: pointers, occupancy, sticky drop flag, beat and packet
    // counters. Reset wins over any simultaneous write or transfer.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            pkt_cnt_q  <= '0;
            beat_q     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, xfer})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (xfer) begin
                beat_q <= (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
                if (M_TLAST) begin
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                end
            end
        end
    end

    assign LEVEL    = level_q;
    assign OVERFLOW = overflow_q;
    assign PKT_CNT  = pkt_cnt_q;
    assign BEAT     = beat_q;

endmodule

// File: tb/tb_data_packetizer.sv
// tb_data_packetizer: directed scenarios against a DEPTH=16/PKT_LEN=8 instance
// with a behavioural occupancy/beat model and a data scoreboard, plus a
// PKT_LEN=1 instance run through 65537 transfers to exercise PKT_CNT wrap.
module tb_data_packetizer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: DEPTH=16, PKT_LEN=8
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] pkt_cnt;
    logic [15:0] beat;

    // instance B: DEPTH=4, PKT_LEN=1
    logic        b_rst;
    logic [31:0] b_tdata;
    logic        b_valid;
    logic [31:0] b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tready;
    logic        b_m_tlast;
    logic [2:0]  b_level;
    logic        b_overflow;
    logic [15:0] b_pkt_cnt;
    logic [15:0] b_beat;

    data_packetizer #(.DEPTH(16), .PKT_LEN(8)) dut (
        .ACLK(clk), .RST(rst), .S_TDATA(s_tdata), .S_VALID(s_valid),
        .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TREADY(m_tready),
        .M_TLAST(m_tlast), .LEVEL(level), .OVERFLOW(overflow),
        .PKT_CNT(pkt_cnt), .BEAT(beat)
    );

    data_packetizer #(.DEPTH(4), .PKT_LEN(1)) dut_b (
        .ACLK(clk), .RST(b_rst), .S_TDATA(b_tdata), .S_VALID(b_valid),
        .M_TDATA(b_m_tdata), .M_TVALID(b_m_tvalid), .M_TREADY(b_m_tready),
        .M_TLAST(b_m_tlast), .LEVEL(b_level), .OVERFLOW(b_overflow),
        .PKT_CNT(b_pkt_cnt), .BEAT(b_beat)
    );

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int mdl_level = 0;
    int mdl_beat  = 0;
    int mdl_pkt   = 0;
    bit mdl_ovf   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance A. Called at a falling edge: drives inputs,
    // checks the pre-edge outputs against the model, advances the model, then
    // waits for the next falling edge and checks post-edge state.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r);
        bit xf;
        bit wr;
        logic [31:0] e;
        s_valid  = v;
        s_tdata  = d;
        m_tready = r;
        #1;
        chk("tvalid", {63'd0, m_tvalid}, {63'd0, mdl_level > 0});
        xf = (mdl_level > 0) && r;
        if (xf) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tdata", {32'd0, m_tdata}, {32'd0, e});
            end
            chk("tlast", {63'd0, m_tlast}, {63'd0, mdl_beat == 7});
        end
        wr = v && ((mdl_level < 16) || xf);
        if (v && !wr) mdl_ovf = 1'b1;
        if (wr) exp_q.push_back(d);
        if (wr && !xf) mdl_level++;
        if (!wr && xf) mdl_level--;
        if (xf) begin
            if (mdl_beat == 7) begin
                mdl_beat = 0;
                mdl_pkt  = (mdl_pkt + 1) % 65536;
            end else begin
                mdl_beat++;
            end
        end
        @(negedge clk);
        chk("level", {59'd0, level}, 64'(mdl_level));
        chk("overflow", {63'd0, overflow}, {63'd0, mdl_ovf});
        chk("pkt_cnt", {48'd0, pkt_cnt}, 64'(mdl_pkt));
    endtask

    // Hold reset for n cycles while offering a word and asserting ready, then
    // verify every output sits at its reset value.
    task automatic do_reset(input int n);
        rst      = 1'b1;
        s_valid  = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        m_tready = 1'b1;
        repeat (n) @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        mdl_level = 0;
        mdl_beat  = 0;
        mdl_pkt   = 0;
        mdl_ovf   = 1'b0;
        #1;
        chk("rst_level", {59'd0, level}, 64'd0);
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_tdata", {32'd0, m_tdata}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        chk("rst_beat", {48'd0, beat}, 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int b_xfers;
        logic [31:0] held;
        rst = 1'b1; s_valid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_tdata = '0; b_m_tready = 1'b0;
        @(negedge clk);
        do_reset(2);

        // 10 words straight through, ready always high
        for (int i = 1; i <= 10; i++) cycle(1'b1, 32'(i), 1'b1);
        repeat (3) cycle(1'b0, 32'd0, 1'b1);
        chk("t1_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);
        chk("t1_beat", {48'd0, beat}, 64'd2);
        chk("t1_overflow", {63'd0, overflow}, 64'd0);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Saturation with ready low, then drain: only 1..16 come out
        do_reset(1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 32'(i), 1'b0);
            if (i == 16) chk("t2_no_ovf_at_16", {63'd0, overflow}, 64'd0);
            if (i == 17) chk("t2_ovf_at_17", {63'd0, overflow}, 64'd1);
        end
        chk("t2_level_full", {59'd0, level}, 64'd16);
        chk("t2_sb_last", 64'(exp_q[15]), 64'd16);
        repeat (18) cycle(1'b0, 32'd0, 1'b1);
        chk("t2_drained", {59'd0, level}, 64'd0);
        chk("t2_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full FIFO with simultaneous write and read for 32 cycles
        do_reset(1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 32'(200 + i), 1'b1);
            chk("t3_level_16", {59'd0, level}, 64'd16);
        end
        chk("t3_overflow", {63'd0, overflow}, 64'd0);
        repeat (17) cycle(1'b0, 32'd0, 1'b1);
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Single word held under backpressure for 5 cycles
        do_reset(1);
        held = 32'($urandom_range(1, 32'h7FFF_FFFF));
        cycle(1'b1, held, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'd0, 1'b0);
            chk("t4_hold_data", {32'd0, m_tdata}, {32'd0, held});
            chk("t4_hold_valid", {63'd0, m_tvalid}, 64'd1);
        end
        cycle(1'b0, 32'd0, 1'b1);
        chk("t4_one_xfer", {59'd0, level}, 64'd0);
        chk("t4_beat", {48'd0, beat}, 64'd1);

        // Reset after 5 beats abandons the partial packet
        do_reset(1);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i), 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("t5_beat_5", {48'd0, beat}, 64'd5);
        do_reset(2);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'($urandom_range(0, 1000)), 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("t5_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);
        chk("t5_beat_0", {48'd0, beat}, 64'd0);

        // PKT_LEN=1: 65537 transfers, TLAST every beat, PKT_CNT wraps to 1
        b_rst = 1'b0;
        b_m_tready = 1'b1;
        b_xfers = 0;
        for (int i = 0; i < 65600; i++) begin
            b_valid = (i < 65537);
            b_tdata = 32'(i);
            #1;
            if (b_m_tvalid && b_m_tready) begin
                b_xfers++;
                if (!b_m_tlast) chk("b_tlast", {63'd0, b_m_tlast}, 64'd1);
            end
            @(negedge clk);
        end
        chk("b_xfers", 64'(b_xfers), 64'd65537);
        chk("b_pkt_cnt", {48'd0, b_pkt_cnt}, 64'd1);
        chk("b_overflow", {63'd0, b_overflow}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_packetizer.md
DATA_PACKETIZER -- requirements
Module: data_packetizer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words; power of two, 4..256.
REQ-002 Parameter PKT_LEN, default 8, beats per output packet; 1..65535.
REQ-003 Port ACLK  input  1  block clock; all logic on rising edge.
REQ-004 Port RST  input  1  synchronous reset, active-high.
REQ-005 Port S_TDATA  input  32  upstream generator data word.
REQ-006 Port S_VALID  input  1  upstream word valid; the source has no backpressure, so every qualified word is offered exactly once.
REQ-007 Port M_TDATA  output  32  AXI4-Stream data to the downstream consumer.
REQ-008 Port M_TVALID  output  1  AXI4-Stream valid.
REQ-009 Port M_TREADY  input  1  AXI4-Stream ready from the downstream consumer.
REQ-010 Port M_TLAST  output  1  marks the final beat of each PKT_LEN-beat packet.
REQ-011 Port LEVEL  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-012 Port OVERFLOW  output  1  sticky flag: at least one input word was dropped.
REQ-013 Port PKT_CNT  output  16  count of completed packets, wrapping modulo 2^16.
REQ-014 The block has one clock (ACLK); reset RST is synchronous and active-high.

Function
REQ-015 Output handshake: a beat transfers when M_TVALID and M_TREADY are both 1 on a rising ACLK edge.
REQ-016 Input write: S_VALID=1 writes S_TDATA if LEVEL<DEPTH, or if LEVEL=DEPTH and an output beat transfers in the same cycle.
REQ-017 Drop: S_VALID=1 with LEVEL=DEPTH and no output transfer discards the word; OVERFLOW is set to 1 on the next edge and stays 1 until reset.
REQ-018 LEVEL: +1 on write only, -1 on transfer only, unchanged on both or neither; it never exceeds DEPTH or underflows.
REQ-019 First-word-fall-through: a word written into an empty FIFO at edge N is on M_TDATA with M_TVALID=1 after edge N; latency is 1 cycle.
REQ-020 M_TVALID=1 exactly when LEVEL>0.
REQ-021 While M_TVALID=1 and M_TREADY=0, M_TDATA and M_TLAST remain stable.
REQ-022 Order is preserved: output words equal accepted input words in order, with no duplication.
REQ-023 Read and write pointers wrap modulo DEPTH.
REQ-024 Beat counter BEAT runs 0..PKT_LEN-1, increments on each transfer, and wraps to 0 after the transfer at PKT_LEN-1.
REQ-025 M_TLAST = M_TVALID and (BEAT = PKT_LEN-1); with PKT_LEN=1, every beat has M_TLAST=1.
REQ-026 PKT_CNT increments by 1 on each transfer with M_TLAST=1, and wraps from 65535 to 0.
REQ-027 Packet boundaries depend only on output transfers, not on input gaps or drops; a packet may span FIFO-empty periods.
REQ-028 Outputs are driven only by registers or by combinational decode of registered state; there is no combinational path from S_* to M_*.

Reset
REQ-029 When RST=1 at an edge, after that edge: LEVEL=0, M_TVALID=0, M_TLAST=0, M_TDATA=0, OVERFLOW=0, PKT_CNT=0, BEAT=0, and both pointers are 0.
REQ-030 RST has priority over simultaneous S_VALID and output transfer; a word offered in the reset cycle is discarded without setting OVERFLOW.
REQ-031 Reset mid-packet abandons the partial packet; the first beat after reset starts a new packet with BEAT=0.
REQ-032 FIFO storage contents need no reset; only the control state is reset.

Verification
REQ-033 DEPTH=16, PKT_LEN=8; S_VALID=1 for 10 cycles with data 1..10; M_TREADY=1 -> 10 beats 1..10, TLAST only on 8, PKT_CNT=1, OVERFLOW=0, BEAT=2 at end.
REQ-034 M_TREADY=0; 20 words 1..20 offered -> LEVEL saturates at 16, OVERFLOW=1 from the 17th word onward; after releasing M_TREADY, the outputs are exactly 1..16.
REQ-035 LEVEL=16 with S_VALID=1 and M_TREADY=1 every cycle for 32 cycles -> LEVEL stays 16, no drops, OVERFLOW=0, the output sequence is contiguous.
REQ-036 Single write into an empty FIFO with M_TREADY=0 for 5 cycles -> M_TVALID=1 from cycle 1, M_TDATA stable for all 5 cycles, and a single transfer once M_TREADY=1.
REQ-037 RST pulsed for 2 cycles after 5 of 8 beats -> all outputs at reset values; the next 8 transfers give TLAST on the 8th, and PKT_CNT=1.
REQ-038 PKT_LEN=1, 65537 transfers -> TLAST on every beat, PKT_CNT=1 (wrapped).
